// File: rtl/mp64_rom_arb.sv
// mp64_rom_arb
// ------------
// Shares one single-port synchronous ROM between two read requesters.
// At most one read is accepted per cycle. Arbitration is round-robin and
// remembers the last winner. Each issued read is tracked by a {valid, id}
// tag in a pipeline whose depth matches the ROM read latency. When the
// data comes back, the tag steers it to the requester that issued the read.
// Responses have no backpressure, so the arbiter never stalls.
//
// Parameters
//   ADDR_W   ROM word-address width (must match the ROM)
//   DATA_W   ROM data width (must match the ROM)
//   ROM_LAT  ROM read latency: 1 (ROM without output register) or
//            2 (ROM with output register); other values are illegal
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0_valid/addr       requester 0 read request (held until accepted)
//   req0_ready            requester 0 accepted this cycle
//   rsp0_valid/data       requester 0 read data (single-cycle pulse)
//   req1_*, rsp1_*        the same for requester 1
//   rom_ce, rom_addr      ROM read enable and word address
//   rom_rdata             ROM read data
module mp64_rom_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata
);

    // Keep the tag pipeline at least one stage deep. An illegal ROM_LAT
    // then still elaborates, and the assertion below can report it.
    localparam int STAGES = (ROM_LAT < 1) ? 1 : ROM_LAT;

    logic              run_q;      // low for the first cycle out of reset
    logic              last_q;     // id of the most recent grant
    logic              grant_any;
    logic              grant_id;
    logic [ADDR_W-1:0] grant_addr;

    logic [STAGES-1:0] tag_v_q;
    logic [STAGES-1:0] tag_id_q;

    // ------------------------------------------------------------------
    // Grant selection. On a tie, the requester that did not win last
    // time gets the grant, so a continuously valid requester waits at
    // most one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = 1'b0;
        grant_addr = '0;
        if (run_q) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
        if (grant_any) begin
            grant_addr = grant_id ? req1_addr : req0_addr;
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    // A grant always means a ROM read. The arbiter holds no request state,
    // so each accept gives exactly one read.
    assign rom_ce   = grant_any;
    assign rom_addr = grant_addr;

    // ------------------------------------------------------------------
    // Run flag and round-robin memory. last_q resets to 1 so that
    // requester 0 wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            run_q <= 1'b1;
            if (grant_any) begin
                last_q <= grant_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline. Stage 0 captures this cycle's grant at the same edge
    // on which the ROM captures the address. Each later stage adds one
    // cycle, so the last stage lines up with rom_rdata. Reset clears
    // every valid bit, so the response of a read in flight during reset
    // is never presented.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q[0]  <= grant_any;
            tag_id_q[0] <= grant_id;
            for (int i = 1; i < STAGES; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // Only one tag sits in the output stage, so the two valids are
    // mutually exclusive by construction. Both ports carry the ROM data.
    // Each port's data is meaningful only while its valid is high.
    assign rsp0_valid = tag_v_q[STAGES-1] & ~tag_id_q[STAGES-1];
    assign rsp1_valid = tag_v_q[STAGES-1] &  tag_id_q[STAGES-1];
    assign rsp0_data  = rom_rdata;
    assign rsp1_data  = rom_rdata;

    // ------------------------------------------------------------------
    // Simulation-only sanity checks.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        assert (ROM_LAT == 1 || ROM_LAT == 2)
            else $error("mp64_rom_arb: ROM_LAT=%0d is illegal, use 1 or 2", ROM_LAT);
        if (rst_n) begin
            assert (!(rsp0_valid && rsp1_valid))
                else $error("mp64_rom_arb: both response valids asserted");
        end
    end

endmodule

// File: tb/tb_mp64_rom_arb.sv
// Bench for mp64_rom_arb. It runs two instances side by side from the
// same stimulus: one with ROM_LAT=1 and one with ROM_LAT=2 (the
// output-registered ROM). A behavioural ROM model feeds each instance.
// A cycle-level model predicts grants and response slots for both
// instances. Directed literal checks pin the key scenarios.
module tb_mp64_rom_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0;
    logic req1_valid = 1'b0;
    logic [7:0] req0_addr = 8'h00;
    logic [7:0] req1_addr = 8'h00;

    logic [1:0] rdy0, rdy1, rv0, rv1, ce;
    logic [1:0][7:0]  raddr;
    logic [1:0][31:0] d0, d1, rdata;
    logic [31:0] rom1_q, rom2_a, rom2_b;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    mp64_rom_arb #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(rdy0[0]),
        .rsp0_valid(rv0[0]), .rsp0_data(d0[0]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(rdy1[0]),
        .rsp1_valid(rv1[0]), .rsp1_data(d1[0]),
        .rom_ce(ce[0]), .rom_addr(raddr[0]), .rom_rdata(rdata[0])
    );

    mp64_rom_arb #(.ADDR_W(8), .DATA_W(32), .ROM_LAT(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(rdy0[1]),
        .rsp0_valid(rv0[1]), .rsp0_data(d0[1]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(rdy1[1]),
        .rsp1_valid(rv1[1]), .rsp1_data(d1[1]),
        .rom_ce(ce[1]), .rom_addr(raddr[1]), .rom_rdata(rdata[1])
    );

    // ROM image: word i = 0xA500_0000 | i
    always @(posedge clk) begin
        if (ce[0]) rom1_q <= 32'hA500_0000 | {24'h0, raddr[0]};
        if (ce[1]) rom2_a <= 32'hA500_0000 | {24'h0, raddr[1]};
        rom2_b <= rom2_a;
    end
    assign rdata[0] = rom1_q;
    assign rdata[1] = rom2_b;

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s lat%0d cycle %0d: got %h expected %h", name, d + 1, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Each cycle it picks the winner from the valid
    // requesters and the previous winner. A winner schedules a response
    // ROM_LAT cycles later in a small time-indexed slot table. Reset
    // wipes the table.
    // ------------------------------------------------------------------
    bit          run_m  [2] = '{1'b0, 1'b0};
    bit          last_m [2] = '{1'b1, 1'b1};
    bit          slot_v [2][8];
    bit          slot_p [2][8];
    logic [31:0] slot_d [2][8];

    initial begin
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) slot_v[d][k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin : mdl
                int lat;
                int s;
                bit gany;
                bit win;
                logic [7:0] a;
                lat  = d + 1;
                s    = cyc % 8;
                gany = 1'b0;
                win  = 1'b0;
                if (!rst_n) begin
                    run_m[d]  = 1'b0;
                    last_m[d] = 1'b1;
                    for (int k = 0; k < 8; k++) slot_v[d][k] = 1'b0;
                end else begin
                    gany = run_m[d] && (req0_valid || req1_valid);
                    if (req0_valid && !req1_valid)      win = 1'b0;
                    else if (req1_valid && !req0_valid) win = 1'b1;
                    else                                win = (last_m[d] == 1'b0);
                end
                a = gany ? (win ? req1_addr : req0_addr) : 8'h00;
                chk("req0_ready", d, {31'b0, rdy0[d]}, {31'b0, gany && !win});
                chk("req1_ready", d, {31'b0, rdy1[d]}, {31'b0, gany && win});
                chk("rom_ce",     d, {31'b0, ce[d]},   {31'b0, gany});
                chk("rom_addr",   d, {24'b0, raddr[d]}, {24'b0, a});
                chk("rsp0_valid", d, {31'b0, rv0[d]}, {31'b0, slot_v[d][s] && !slot_p[d][s]});
                chk("rsp1_valid", d, {31'b0, rv1[d]}, {31'b0, slot_v[d][s] && slot_p[d][s]});
                if (slot_v[d][s]) begin
                    if (slot_p[d][s]) chk("rsp1_data", d, d1[d], slot_d[d][s]);
                    else              chk("rsp0_data", d, d0[d], slot_d[d][s]);
                end
                slot_v[d][s] = 1'b0;
                if (gany) begin
                    last_m[d] = win;
                    slot_v[d][(cyc + lat) % 8] = 1'b1;
                    slot_p[d][(cyc + lat) % 8] = win;
                    slot_d[d][(cyc + lat) % 8] = 32'hA500_0000 | {24'h0, a};
                end
                if (rst_n) run_m[d] = 1'b1;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] exp_g;

        // Reset and idle: a request during reset is ignored
        req0_valid = 1'b1;
        req0_addr  = 8'h03;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req0_ready", 0, {31'b0, rdy0[0]}, 32'd0);
            chk("rst_rom_ce",     1, {31'b0, ce[1]},   32'd0);
            chk("rst_rsp0_valid", 0, {31'b0, rv0[0]},  32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_ready", 0, {31'b0, rdy0[0]}, 32'd0);
        step();
        @(negedge clk);
        chk("second_cycle_ready", 0, {31'b0, rdy0[0]}, 32'd1);
        chk("second_cycle_ready", 1, {31'b0, rdy0[1]}, 32'd1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("boot_rsp0_valid", 0, {31'b0, rv0[0]}, 32'd1);
        chk("boot_rsp0_data",  0, d0[0], 32'hA500_0003);
        chk("boot_rsp0_early", 1, {31'b0, rv0[1]}, 32'd0);
        step();
        @(negedge clk);
        chk("boot_rsp0_valid", 1, {31'b0, rv0[1]}, 32'd1);
        chk("boot_rsp0_data",  1, d0[1], 32'hA500_0003);

        // Requester 1 streams three back-to-back reads
        step();
        req1_valid = 1'b1;
        req1_addr  = 8'h10;
        step();
        req1_addr = 8'h11;
        step();
        req1_addr = 8'h12;
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", 0, {31'b0, rv1[0]}, 32'd1);
        chk("stream_last_data",  0, d1[0], 32'hA500_0012);
        repeat (3) step();

        // Contention: the grant sequence must be 0,1,0,1
        req0_valid = 1'b1;
        req0_addr  = 8'h20;
        req1_valid = 1'b1;
        req1_addr  = 8'h40;
        exp_g = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("contend_req0_ready", 0, {31'b0, rdy0[0]}, {31'b0, exp_g[3-i]});
            chk("contend_req0_ready", 1, {31'b0, rdy0[1]}, {31'b0, exp_g[3-i]});
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("contend_last_rsp1", 0, {31'b0, rv1[0]}, 32'd1);
        chk("contend_last_data", 0, d1[0], 32'hA500_0040);
        repeat (3) step();

        // Round-robin memory: grant 1 alone, idle 3 cycles, then a tie
        req1_valid = 1'b1;
        req1_addr  = 8'h01;
        step();
        req1_valid = 1'b0;
        repeat (3) step();
        req0_valid = 1'b1;
        req0_addr  = 8'h30;
        req1_valid = 1'b1;
        req1_addr  = 8'h50;
        @(negedge clk);
        chk("rr_first_grant0", 0, {31'b0, rdy0[0]}, 32'd1);
        chk("rr_first_grant1", 0, {31'b0, rdy1[0]}, 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rr_second_grant1", 0, {31'b0, rdy1[0]}, 32'd1);
        step();
        req1_valid = 1'b0;
        repeat (3) step();

        // Reset mid-flight: the read accepted just before reset is never answered
        req0_valid = 1'b1;
        req0_addr  = 8'h05;
        step();
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_rsp0_valid", 0, {31'b0, rv0[0]}, 32'd0);
            chk("midrst_rsp0_valid", 1, {31'b0, rv0[1]}, 32'd0);
            step();
            if (i == 1) rst_n = 1'b1;
        end

        // Recovery after reset
        req1_valid = 1'b1;
        req1_addr  = 8'h7F;
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("recover_rsp1_data", 0, d1[0], 32'hA500_007F);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mp64_rom_arb.md
Name: mp64_rom_arb

Overview:
Two-requester round-robin arbiter that shares one single-port synchronous ROM instance (mp64_rom) between two clients, e.g. instruction fetch and a boot/table walker. It accepts at most one read per cycle and issues it to the ROM. It tracks each in-flight read through a latency-matched tag pipeline and routes each returned word to the requester that issued it. Responses have no backpressure, so the arbiter itself never stalls.

Parameters:
ADDR_W, 8, ROM word-address width; must equal the ROM's ADDR_W.
DATA_W, 32, ROM data width; must equal the ROM's DATA_W.
ROM_LAT, 1, ROM read latency in cycles. Set to 1 for a ROM with OUT_REG=0 and 2 for OUT_REG=1; any other value is illegal and must be flagged by a simulation-time assertion.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 read request
req0_addr  in  ADDR_W  requester 0 word address
req0_ready  out  1  request 0 accepted this cycle
rsp0_valid  out  1  read data for requester 0 present this cycle (1-cycle pulse)
rsp0_data  out  DATA_W  read data for requester 0
req1_valid  in  1  requester 1 read request
req1_addr  in  ADDR_W  requester 1 word address
req1_ready  out  1  request 1 accepted this cycle
rsp1_valid  out  1  read data for requester 1 present this cycle (1-cycle pulse)
rsp1_data  out  DATA_W  read data for requester 1
rom_ce  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM address
rom_rdata  in  DATA_W  ROM read data

Behaviour:
- Reset (async assert, sync deassert internally handled by system):
  - run_q=0, last_q=1 (so requester 0 wins the first tie), tag pipeline valid bits all 0.
  - While run_q=0: req0_ready=req1_ready=0, rom_ce=0, rsp*_valid=0, rom_addr=0, rsp*_data are don't-care.
- run_q sets 1 on the first clk edge after rst_n deasserts, so the first grant is possible in the second cycle out of reset.
- Grant logic (combinational, gated by run_q):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester that is not last_q.
  - last_q updates to the granted id on every cycle with a grant; otherwise it holds.
- reqN_ready is 1 only for the granted requester. Accept occurs when reqN_valid and reqN_ready are both 1.
- Requester protocol:
  - Requester must hold valid and addr stable until accepted.
  - Arbiter holds no request state, so a dropped valid is simply not served.
- ROM drive:
  - rom_ce = grant_any; rom_addr = the granted address, else 0.
  - Exactly one ROM read per accepted request; none otherwise.
- Tag pipeline:
  - ROM_LAT stages of {v, id}. Stage 0 is loaded with {grant_any, grant_id} each cycle; higher stages shift.
  - The output stage drives rspN_valid = v && (id==N).
  - rspN_data = rom_rdata for both ports; data is valid only when rspN_valid is 1.
- Latency:
  - The response arrives exactly ROM_LAT cycles after the accept edge.
  - Fully pipelined: back-to-back accepts give back-to-back responses in issue order.
  - rsp0_valid and rsp1_valid are never both 1 in the same cycle.
- Response has no ready signal. Requesters must sink every response.
- Reset mid-operation:
  - All in-flight tags are cleared immediately and their responses are never presented.
  - ROM output contents after reset are ignored.
- Address width: no translation or wrap; rom_addr is passed through unmodified (ADDR_W bits).
- Starvation bound: a continuously valid requester is granted within 2 cycles, even under contention.

Test Plan:
- ROM image for all tests: word i = 0xA500_0000 | i.
- Reset/idle:
  - Hold rst_n=0 with req0_valid=1.
  - Required: req0_ready=0, rom_ce=0, rsp*_valid=0.
  - After release: first req0_ready=1 in the second cycle; rsp0_data=0xA500_0003 for addr 3 after ROM_LAT cycles.
- Single requester streaming: req1 issues addrs 0x10,0x11,0x12 back-to-back. Required: three consecutive rsp1_valid pulses carrying 0xA500_0010/11/12, and rsp0_valid stays 0.
- Contention:
  - Both requesters valid for 4 cycles; req0 addr=0x20, req1 addr=0x40.
  - Required grants: 0,1,0,1.
  - Required responses, in that order and interleaved: 0xA500_0020 to port 0 and 0xA500_0040 to port 1.
- Round-robin memory:
  - Grant 1 alone, idle 3 cycles, then both requesters valid.
  - Required: requester 0 is granted first.
- Reset mid-flight:
  - Accept a req0 read, then assert rst_n=0 in the next cycle.
  - Required: no rsp0_valid pulse appears during or after reset for that read.
- Latency 2: repeat the contention test with ROM_LAT=2 and ROM OUT_REG=1. Required: each response appears exactly 2 cycles after its accept, with the same values as above.
